// File: rtl/sram_arbiter.sv
// sram_arbiter: sequencer for one 256K x 16 async SRAM shared by two ports.
// Display reads have priority; a pending write is forced after a read streak.
module sram_arbiter #(
  parameter int ACC_CYC       = 2,
  parameter int MAX_RD_STREAK = 8,
  parameter int AW            = 18,
  parameter int DW            = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    wr_be,
  output logic          wr_ack,
  output logic          busy,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  localparam int CW = $clog2(ACC_CYC + 1);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYC - 1);
  localparam logic [SW-1:0] STK_MAX  = SW'(MAX_RD_STREAK);

  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] streak_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dq_o_q;
  logic [DW-1:0] rd_data_q;
  logic          dq_oe_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          ub_n_q;
  logic          lb_n_q;
  logic          rd_ack_q;
  logic          wr_ack_q;
  logic          rd_valid_q;
  logic          busy_q;

  logic idle;
  logic wr_gnt;
  logic rd_gnt;
  logic cnt_last;
  logic [SW-1:0] streak_inc;

  assign idle     = (state_q == IDLE);
  assign wr_gnt   = idle && wr_req &&
                    (!rd_req || streak_q == STK_MAX);
  assign rd_gnt   = idle && rd_req && !wr_gnt;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign streak_inc = (streak_q == STK_MAX) ?
                      streak_q : streak_q + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      addr_q     <= '0;
      dq_o_q     <= '0;
      rd_data_q  <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (wr_gnt) begin
            state_q  <= WR;
            streak_q <= '0;
            addr_q   <= wr_addr;
            dq_o_q   <= wr_data;
            dq_oe_q  <= 1'b1;
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b0;
            ub_n_q   <= ~wr_be[1];
            lb_n_q   <= ~wr_be[0];
            wr_ack_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (rd_gnt) begin
            state_q  <= RD;
            streak_q <= wr_req ? streak_inc : '0;
            addr_q   <= rd_addr;
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b0;
            ub_n_q   <= 1'b0;
            lb_n_q   <= 1'b0;
            rd_ack_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (!wr_req) begin
            streak_q <= '0;
          end
        end
        RD: begin
          if (cnt_last) begin
            state_q    <= IDLE;
            rd_data_q  <= sram_dq_i;
            rd_valid_q <= 1'b1;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WR: begin
          if (cnt_last) begin
            state_q <= TURN;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            // release we_n one cycle early so data is held past the edge
            if (cnt_q + CW'(1) == CNT_LAST)
              we_n_q <= 1'b1;
          end
        end
        TURN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ack     = rd_ack_q;
  assign wr_ack     = wr_ack_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized bench with a behavioural SRAM model and a
// word-level reference memory for sram_arbiter.
module tb_sram_arbiter;

  localparam int ACC = 2;
  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req;
  logic [17:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_ack, rd_valid, wr_ack, busy;
  logic [15:0] rd_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic        sram_ub_n, sram_lb_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_ce = 0, n_oe = 0, n_we = 0, n_dq = 0;
  int n_turn = 0, n_viol = 0;

  bit   [15:0] sram [0:262143];
  logic [15:0] refm [logic [17:0]];

  sram_arbiter #(
    .ACC_CYC(ACC), .MAX_RD_STREAK(MAX), .AW(18), .DW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_ack(wr_ack), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ?
                     sram[sram_addr] : 16'hDEAD;

  // async SRAM model plus bus-activity and bus-contention monitor
  always @(negedge clk) begin
    if (!sram_ce_n) n_ce <= n_ce + 1;
    if (!sram_oe_n) n_oe <= n_oe + 1;
    if (!sram_we_n) n_we <= n_we + 1;
    if (sram_dq_oe) n_dq <= n_dq + 1;
    if (busy && sram_ce_n) n_turn <= n_turn + 1;
    if ((!sram_oe_n && !sram_we_n) ||
        (sram_dq_oe && (!sram_oe_n || sram_ce_n)))
      n_viol <= n_viol + 1;
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) sram[sram_addr][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n) sram[sram_addr][7:0]  <= sram_dq_o[7:0];
    end
  end

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return refm.exists(a) ? refm[a] : 16'h0000;
  endfunction

  function automatic void ref_wr(input logic [17:0] a,
                                 input logic [15:0] d,
                                 input logic [1:0] be);
    logic [15:0] w;
    w = ref_rd(a);
    if (be[1]) w[15:8] = d[15:8];
    if (be[0]) w[7:0]  = d[7:0];
    refm[a] = w;
  endfunction

  task automatic rd_txn(input logic [17:0] a, output logic [15:0] d,
                        output int la, output int lv);
    int c0;
    la = -1; lv = -1; d = 16'hxxxx;
    @(negedge clk);
    rd_addr = a; rd_req = 1'b1; c0 = cyc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_ack) begin la = cyc - c0; break; end
    end
    rd_req = 1'b0;
    if (la < 0) return;
    c0 = cyc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_valid) begin lv = cyc - c0; d = rd_data; break; end
    end
  endtask

  task automatic wr_txn(input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be, output int la,
                        output int ld, output logic ub_s,
                        output logic lb_s);
    int c0;
    la = -1; ld = -1; ub_s = 1'bx; lb_s = 1'bx;
    @(negedge clk);
    wr_addr = a; wr_data = d; wr_be = be; wr_req = 1'b1; c0 = cyc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_ack) begin
        la = cyc - c0; ub_s = sram_ub_n; lb_s = sram_lb_n; break;
      end
    end
    wr_req = 1'b0;
    if (la < 0) return;
    ref_wr(a, d, be);
    c0 = cyc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin ld = cyc - c0; break; end
    end
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    rst_n = 1'b0;
    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0;
    wr_data = '0; wr_be = '0;
    repeat (3) @(negedge clk);
    ctl = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
           sram_dq_oe, rd_ack, wr_ack, rd_valid, busy};
    n_tests++;
    if (ctl !== 10'b11111_00000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, 10'b1111100000);
    end
    n_tests++;
    if ({sram_addr, sram_dq_o, rd_data} !== 50'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0",
               {sram_addr, sram_dq_o, rd_data});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, sram_ce_n, sram_dq_oe} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 010",
               {busy, sram_ce_n, sram_dq_oe});
    end
  endtask

  task automatic test_single_read();
    logic [15:0] d;
    int la, lv, ld, ce0, oe0;
    logic u, l;
    wr_txn(18'h00010, 16'hAB12, 2'b11, la, ld, u, l);
    ce0 = n_ce; oe0 = n_oe;
    rd_txn(18'h00010, d, la, lv);
    n_tests++;
    if (d !== 16'hAB12) begin
      n_fail++; $display("FAIL rd1_data: got %h expected ab12", d);
    end
    n_tests++;
    if (la !== 1) begin
      n_fail++; $display("FAIL rd1_ack_lat: got %0d expected 1", la);
    end
    n_tests++;
    if (lv !== ACC) begin
      n_fail++; $display("FAIL rd1_valid_lat: got %0d expected %0d", lv, ACC);
    end
    n_tests++;
    if (n_ce - ce0 !== ACC || n_oe - oe0 !== ACC) begin
      n_fail++;
      $display("FAIL rd1_strobe: got ce %0d oe %0d expected %0d",
               n_ce - ce0, n_oe - oe0, ACC);
    end
  endtask

  task automatic test_single_write();
    int la, ld, we0, dq0, tu0;
    logic u, l;
    we0 = n_we; dq0 = n_dq; tu0 = n_turn;
    wr_txn(18'h3FFFF, 16'h55AA, 2'b11, la, ld, u, l);
    n_tests++;
    if (la !== 1) begin
      n_fail++; $display("FAIL wr1_ack_lat: got %0d expected 1", la);
    end
    n_tests++;
    if (n_we - we0 !== ACC - 1) begin
      n_fail++;
      $display("FAIL wr1_we_cyc: got %0d expected %0d", n_we - we0, ACC - 1);
    end
    n_tests++;
    if (n_dq - dq0 !== ACC) begin
      n_fail++;
      $display("FAIL wr1_oe_cyc: got %0d expected %0d", n_dq - dq0, ACC);
    end
    n_tests++;
    if (n_turn - tu0 !== 1) begin
      n_fail++;
      $display("FAIL wr1_turn: got %0d expected 1", n_turn - tu0);
    end
    n_tests++;
    if (ld !== ACC + 1) begin
      n_fail++; $display("FAIL wr1_busy: got %0d expected %0d", ld, ACC + 1);
    end
    n_tests++;
    if (sram[18'h3FFFF] !== 16'h55AA) begin
      n_fail++;
      $display("FAIL wr1_mem: got %h expected 55aa", sram[18'h3FFFF]);
    end
  endtask

  task automatic test_byte_write();
    logic [15:0] d;
    int la, lv, ld;
    logic u, l;
    wr_txn(18'h00020, 16'hFFFF, 2'b11, la, ld, u, l);
    wr_txn(18'h00020, 16'h1234, 2'b01, la, ld, u, l);
    n_tests++;
    if ({u, l} !== 2'b10) begin
      n_fail++; $display("FAIL bw_strobes: got %b expected 10", {u, l});
    end
    rd_txn(18'h00020, d, la, lv);
    n_tests++;
    if (d !== 16'hFF34) begin
      n_fail++; $display("FAIL bw_readback: got %h expected ff34", d);
    end
    wr_txn(18'h00020, 16'h0000, 2'b00, la, ld, u, l);
    n_tests++;
    if (la !== 1 || {u, l} !== 2'b11) begin
      n_fail++;
      $display("FAIL be00_ack: got lat %0d ub/lb %b expected 1 11",
               la, {u, l});
    end
    rd_txn(18'h00020, d, la, lv);
    n_tests++;
    if (d !== 16'hFF34) begin
      n_fail++; $display("FAIL be00_readback: got %h expected ff34", d);
    end
  endtask

  task automatic test_contention();
    logic [15:0] expq[$];
    logic [15:0] e;
    int nrd, round, resumed;
    int rb [2];
    nrd = 0; round = 0; resumed = 0; rb[0] = -1; rb[1] = -1;
    @(negedge clk);
    rd_addr = 18'($urandom_range(0, 255)); rd_req = 1'b1;
    wr_addr = 18'($urandom_range(0, 255));
    wr_data = 16'($urandom); wr_be = 2'($urandom); wr_req = 1'b1;
    for (int i = 0; i < 118; i++) begin
      @(negedge clk);
      if (i == 117) rd_req = 1'b0;
      if (rd_valid) begin
        e = 16'hxxxx;
        if (expq.size() > 0) e = expq.pop_front();
        n_tests++;
        if (rd_data !== e) begin
          n_fail++; $display("FAIL cont_rd_data: got %h expected %h", rd_data, e);
        end
      end
      if (rd_ack) begin
        expq.push_back(ref_rd(rd_addr));
        nrd++;
        if (round == 2) resumed++;
        rd_addr = 18'($urandom_range(0, 255));
      end
      if (wr_ack) begin
        ref_wr(wr_addr, wr_data, wr_be);
        if (round < 2) rb[round] = nrd;
        nrd = 0; round++;
        wr_addr = 18'($urandom_range(0, 255));
        wr_data = 16'($urandom); wr_be = 2'($urandom);
        wr_req = (round < 2);
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rd_valid) begin
        e = 16'hxxxx;
        if (expq.size() > 0) e = expq.pop_front();
        n_tests++;
        if (rd_data !== e) begin
          n_fail++; $display("FAIL cont_rd_drain: got %h expected %h", rd_data, e);
        end
      end
    end
    n_tests++;
    if (rb[0] !== MAX) begin
      n_fail++; $display("FAIL cont_streak1: got %0d expected %0d", rb[0], MAX);
    end
    n_tests++;
    if (rb[1] !== MAX) begin
      n_fail++; $display("FAIL cont_streak2: got %0d expected %0d", rb[1], MAX);
    end
    n_tests++;
    if (resumed < 1 || expq.size() != 0) begin
      n_fail++;
      $display("FAIL cont_resume: got %0d reads, %0d pending expected >0, 0",
               resumed, expq.size());
    end
  endtask

  task automatic test_simultaneous();
    int c0, t_rd, t_wr;
    t_rd = -1; t_wr = -1;
    repeat (2) @(negedge clk);
    rd_addr = 18'h00010; rd_req = 1'b1;
    wr_addr = 18'h00030; wr_data = 16'hC3C3; wr_be = 2'b11;
    wr_req = 1'b1; c0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_ack && t_rd < 0) begin t_rd = cyc - c0; rd_req = 1'b0; end
      if (wr_ack && t_wr < 0) begin
        t_wr = cyc - c0; wr_req = 1'b0;
        ref_wr(wr_addr, wr_data, wr_be);
      end
      if (t_wr >= 0 && !busy) break;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    n_tests++;
    if (t_rd !== 1) begin
      n_fail++; $display("FAIL sim_rd_first: got %0d expected 1", t_rd);
    end
    n_tests++;
    if (t_wr !== ACC + 2) begin
      n_fail++; $display("FAIL sim_wr_next: got %0d expected %0d", t_wr, ACC + 2);
    end
  endtask

  task automatic test_random();
    logic [17:0] a;
    logic [15:0] d, e;
    logic [1:0] be;
    int la, lv, ld;
    logic u, l;
    for (int i = 0; i < 40; i++) begin
      a = 18'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        e = ref_rd(a);
        rd_txn(a, d, la, lv);
        n_tests++;
        if (d !== e || la !== 1 || lv !== ACC) begin
          n_fail++;
          $display("FAIL rnd_rd[%0d]: got %h lat %0d/%0d expected %h 1/%0d",
                   i, d, la, lv, e, ACC);
        end
      end else begin
        d = 16'($urandom); be = 2'($urandom);
        wr_txn(a, d, be, la, ld, u, l);
        n_tests++;
        if (la !== 1 || ld !== ACC + 1 || {u, l} !== ~be) begin
          n_fail++;
          $display("FAIL rnd_wr[%0d]: got lat %0d/%0d ub/lb %b expected 1/%0d %b",
                   i, la, ld, {u, l}, ACC + 1, ~be);
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wr();
    logic [15:0] d;
    int la, lv, spur;
    bit seen;
    spur = 0; seen = 0;
    @(negedge clk);
    wr_addr = 18'h2AAAA; wr_data = 16'h0F0F; wr_be = 2'b11; wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ack) begin seen = 1; break; end
    end
    wr_req = 1'b0;
    n_tests++;
    if (!seen || sram_we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_in_write: got ack %0d we_n %b expected 1 0", seen, sram_we_n);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sram_we_n, sram_ce_n, sram_dq_oe, busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rmw_abort: got %b expected 1100",
               {sram_we_n, sram_ce_n, sram_dq_oe, busy});
    end
    repeat (3) begin
      @(negedge clk);
      if (wr_ack || rd_valid || rd_ack) spur++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (wr_ack || rd_valid || rd_ack || busy) spur++;
    end
    n_tests++;
    if (spur !== 0) begin
      n_fail++; $display("FAIL rmw_spurious: got %0d expected 0", spur);
    end
    rd_txn(18'h00010, d, la, lv);
    n_tests++;
    if (d !== ref_rd(18'h00010) || la !== 1 || lv !== ACC) begin
      n_fail++;
      $display("FAIL rmw_after: got %h lat %0d/%0d expected %h 1/%0d",
               d, la, lv, ref_rd(18'h00010), ACC);
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (n_viol !== 0) begin
      n_fail++; $display("FAIL bus_invariant: got %0d violations expected 0", n_viol);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_byte_write();
    test_contention();
    test_simultaneous();
    test_random();
    test_reset_mid_wr();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
